// File: rtl/dig_map_pkg.sv
// dig_map_pkg: shared constants, types and init pattern for the dug-tile map.
// DIG_MAP_INIT_TUNNEL_EN pre-digs a starting tunnel in column 15, rows 0-5.
package dig_map_pkg;
  localparam int MAP_COLS = 32;
  localparam int MAP_ROWS = 24;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_Y_ORIGIN = 96;
  localparam int MAP_TILES = 768;
  typedef logic [MAP_ROWS-1:0] dug_col_t;
  typedef dug_col_t [MAP_COLS-1:0] dug_map_t;
  typedef enum logic {IDLE, CLEAR} dig_state_t;
`ifdef DIG_MAP_INIT_TUNNEL_EN
  localparam dug_col_t TUNNEL_COL = 24'h00003F;
  localparam int INIT_COUNT_DEF = 6;
`else
  localparam dug_col_t TUNNEL_COL = '0;
  localparam int INIT_COUNT_DEF = 0;
`endif
  function automatic dug_col_t init_col(input logic [4:0] col);
    return (col == 5'd15) ? TUNNEL_COL : '0;
  endfunction
  function automatic dug_map_t init_map();
    dug_map_t m;
    for (int i = 0; i < MAP_COLS; i++) m[i] = init_col(5'(i));
    return m;
  endfunction
endpackage

// File: rtl/dig_map_if.sv
// dig_map_if: frame/digger/query inputs and map/status outputs of dig_map.
interface dig_map_if;
  import dig_map_pkg::*;
  logic frame_clk;
  logic [9:0] Digger_X, Digger_Y;
  logic Dig_en, Clear_map;
  logic [9:0] DrawX, DrawY;
  dug_map_t dug_state;
  logic is_dug, newly_dug;
  logic [9:0] dug_count;
  logic all_dug, Busy;
  modport master(output frame_clk, Digger_X, Digger_Y, Dig_en, Clear_map, DrawX, DrawY,
                 input dug_state, is_dug, newly_dug, dug_count, all_dug, Busy);
  modport slave(input frame_clk, Digger_X, Digger_Y, Dig_en, Clear_map, DrawX, DrawY,
                output dug_state, is_dug, newly_dug, dug_count, all_dug, Busy);
endinterface

// File: rtl/dig_map_pix_to_tile.sv
// pix_to_tile: pixel coordinate to map tile; range is checked before the shift.
module pix_to_tile import dig_map_pkg::*; (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [4:0] col,
  output logic [4:0] row,
  output logic       valid
);
  assign col = 5'(x >> TILE_SHIFT);
  assign row = 5'((y - 10'(MAP_Y_ORIGIN)) >> TILE_SHIFT);
  assign valid = (x < 10'(MAP_COLS << TILE_SHIFT)) && (y >= 10'(MAP_Y_ORIGIN)) &&
                 (y < 10'(MAP_Y_ORIGIN + (MAP_ROWS << TILE_SHIFT)));
endmodule

// File: rtl/dig_map.sv
// dig_map: dug-tile map with per-frame marking, tile count, pixel query and clear sweep.
// Init pattern and INIT_COUNT default follow DIG_MAP_INIT_TUNNEL_EN.
module dig_map import dig_map_pkg::*; #(
  parameter int INIT_COUNT = INIT_COUNT_DEF
) (
  input logic Clk,
  input logic Reset,
  dig_map_if.slave bus
);
  dig_state_t state, state_n;
  logic [4:0] col_idx, col_idx_n, d_col, d_row, q_col, q_row;
  logic d_valid, q_valid, frame_clk_delayed, edge_p, is_dug_q, newly_dug_q, newly_dug_n;
  dug_map_t map_q, map_n;
  logic [9:0] count_q, count_n;
  pix_to_tile u_dig (.x(bus.Digger_X), .y(bus.Digger_Y), .col(d_col), .row(d_row), .valid(d_valid));
  pix_to_tile u_qry (.x(bus.DrawX), .y(bus.DrawY), .col(q_col), .row(q_row), .valid(q_valid));
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      col_idx <= '0;
      map_q <= init_map();
      count_q <= 10'(INIT_COUNT);
      frame_clk_delayed <= 1'b0;
      edge_p <= 1'b0;
      is_dug_q <= 1'b0;
      newly_dug_q <= 1'b0;
    end else begin
      state <= state_n;
      col_idx <= col_idx_n;
      map_q <= map_n;
      count_q <= count_n;
      frame_clk_delayed <= bus.frame_clk;
      edge_p <= bus.frame_clk & ~frame_clk_delayed;
      is_dug_q <= q_valid ? map_q[q_col][q_row] : 1'b0;
      newly_dug_q <= newly_dug_n;
    end
  end
  // A clear request wins over a same-cycle frame edge, which is simply dropped.
  always_comb begin
    state_n = state;
    col_idx_n = col_idx;
    map_n = map_q;
    count_n = count_q;
    newly_dug_n = 1'b0;
    if (state == CLEAR) begin
      map_n[col_idx] = init_col(col_idx);
      col_idx_n = col_idx + 5'd1;
      state_n = (col_idx == 5'(MAP_COLS - 1)) ? IDLE : CLEAR;
    end else if (bus.Clear_map) begin
      state_n = CLEAR;
      col_idx_n = '0;
      count_n = 10'(INIT_COUNT);
    end else if (edge_p && bus.Dig_en && d_valid && !map_q[d_col][d_row]) begin
      map_n[d_col][d_row] = 1'b1;
      count_n = (count_q == 10'(MAP_TILES)) ? count_q : count_q + 10'd1;
      newly_dug_n = 1'b1;
    end
  end
  assign bus.dug_state = map_q;
  assign bus.is_dug = is_dug_q;
  assign bus.newly_dug = newly_dug_q;
  assign bus.dug_count = count_q;
  assign bus.all_dug = (count_q == 10'(MAP_TILES));
  assign bus.Busy = (state == CLEAR);
endmodule

// File: tb/tb_dig_map.sv
// tb_dig_map: directed vector bench for dig_map (marking, query, clear sweep, reset, saturation).
module tb_dig_map;
`ifdef DIG_MAP_INIT_TUNNEL_EN
  localparam int INIT_CNT = 6;
  localparam logic [23:0] C15 = 24'h00003F;
`else
  localparam int INIT_CNT = 0;
  localparam logic [23:0] C15 = 24'h0;
`endif
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  dig_map_if bus();
  dig_map dut (.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  int tests = 0;
  int fails = 0;
  logic [31:0][23:0] exp_init, exp_map;
  typedef struct {
    logic [9:0] x, y;
    logic en, exp_new;
    int exp_cnt;
    logic [4:0] c, r;
    logic exp_bit;
  } vec_t;
  typedef struct {
    logic [9:0] x, y;
    logic exp;
  } qry_t;
  vec_t v[9];
  qry_t q[8];
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int n, busy;
    logic nd_seen;
    v[0] = '{10'd40,  10'd130, 1'b1, 1'b1, 1, 5'd2,  5'd2,  1'b1};
    v[1] = '{10'd40,  10'd130, 1'b1, 1'b0, 1, 5'd2,  5'd2,  1'b1};
    v[2] = '{10'd40,  10'd146, 1'b0, 1'b0, 1, 5'd2,  5'd3,  1'b0};
    v[3] = '{10'd40,  10'd90,  1'b1, 1'b0, 1, 5'd2,  5'd0,  1'b0};
    v[4] = '{10'd520, 10'd130, 1'b1, 1'b0, 1, 5'd0,  5'd2,  1'b0};
    v[5] = '{10'd511, 10'd479, 1'b1, 1'b1, 2, 5'd31, 5'd23, 1'b1};
    v[6] = '{10'd0,   10'd96,  1'b1, 1'b1, 3, 5'd0,  5'd0,  1'b1};
    v[7] = '{10'd512, 10'd112, 1'b1, 1'b0, 3, 5'd0,  5'd1,  1'b0};
    v[8] = '{10'd0,   10'd480, 1'b1, 1'b0, 3, 5'd0,  5'd23, 1'b0};
    q[0] = '{10'd40,  10'd130, 1'b1};
    q[1] = '{10'd47,  10'd143, 1'b1};
    q[2] = '{10'd40,  10'd50,  1'b0};
    q[3] = '{10'd40,  10'd146, 1'b0};
    q[4] = '{10'd511, 10'd479, 1'b1};
    q[5] = '{10'd512, 10'd479, 1'b0};
    q[6] = '{10'd0,   10'd96,  1'b1};
    q[7] = '{10'd0,   10'd95,  1'b0};
    exp_init = '0;
    exp_init[15] = C15;
    bus.frame_clk = 1'b0;
    bus.Digger_X = '0;
    bus.Digger_Y = '0;
    bus.Dig_en = 1'b0;
    bus.Clear_map = 1'b0;
    bus.DrawX = '0;
    bus.DrawY = '0;
    tick();
    tick();
    chk("rst_count", bus.dug_count, INIT_CNT);
    chk("rst_map", bus.dug_state, exp_init);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_all_dug", bus.all_dug, 0);
    chk("rst_newly", bus.newly_dug, 0);
    chk("rst_is_dug", bus.is_dug, 0);
    Reset = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      bus.Digger_X = v[i].x;
      bus.Digger_Y = v[i].y;
      bus.Dig_en = v[i].en;
      bus.frame_clk = 1'b1;
      tick();
      tick();
      chk($sformatf("vec%0d_newly", i), bus.newly_dug, v[i].exp_new);
      chk($sformatf("vec%0d_count", i), bus.dug_count, INIT_CNT + v[i].exp_cnt);
      chk($sformatf("vec%0d_bit", i), bus.dug_state[v[i].c][v[i].r], v[i].exp_bit);
      bus.frame_clk = 1'b0;
      tick();
      chk($sformatf("vec%0d_pulse_end", i), bus.newly_dug, 0);
      tick();
    end
    exp_map = exp_init;
    exp_map[2][2] = 1'b1;
    exp_map[31][23] = 1'b1;
    exp_map[0][0] = 1'b1;
    chk("map_after_vecs", bus.dug_state, exp_map);
    for (int i = 0; i < 8; i++) begin
      bus.DrawX = q[i].x;
      bus.DrawY = q[i].y;
      tick();
      chk($sformatf("qry%0d", i), bus.is_dug, q[i].exp);
    end
    bus.DrawX = 10'd40;
    bus.DrawY = 10'd50;
    tick();
    bus.DrawY = 10'd130;
    #1;
    chk("qry_latency_old", bus.is_dug, 0);
    tick();
    chk("qry_latency_new", bus.is_dug, 1);
    bus.Digger_X = 10'd100;
    bus.Digger_Y = 10'd200;
    bus.Dig_en = 1'b1;
    bus.frame_clk = 1'b1;
    tick();
    bus.Clear_map = 1'b1;
    tick();
    bus.Clear_map = 1'b0;
    chk("clr_busy_start", bus.Busy, 1);
    chk("clr_count_load", bus.dug_count, INIT_CNT);
    n = 0;
    busy = 0;
    nd_seen = 1'b0;
    while (bus.Busy && n < 100) begin
      busy++;
      n++;
      if (busy == 2) bus.frame_clk = 1'b0;
      if (busy == 5) bus.frame_clk = 1'b1;
      if (bus.newly_dug) nd_seen = 1'b1;
      tick();
    end
    chk("clr_busy_cycles", busy, 32);
    chk("clr_no_pulse", nd_seen, 0);
    chk("clr_map", bus.dug_state, exp_init);
    chk("clr_count", bus.dug_count, INIT_CNT);
    tick();
    chk("clr_map_settled", bus.dug_state, exp_init);
    bus.frame_clk = 1'b0;
    tick();
    bus.Digger_X = 10'd400;
    bus.Digger_Y = 10'd300;
    bus.frame_clk = 1'b1;
    tick();
    tick();
    chk("pre_sweep_newly", bus.newly_dug, 1);
    chk("pre_sweep_count", bus.dug_count, INIT_CNT + 1);
    bus.frame_clk = 1'b0;
    tick();
    tick();
    bus.Clear_map = 1'b1;
    tick();
    bus.Clear_map = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_sweep_busy", bus.Busy, 1);
    chk("mid_sweep_col25", bus.dug_state[25][12], 1);
    Reset = 1'b1;
    tick();
    chk("rst_sweep_busy", bus.Busy, 0);
    chk("rst_sweep_map", bus.dug_state, exp_init);
    chk("rst_sweep_count", bus.dug_count, INIT_CNT);
    Reset = 1'b0;
    tick();
    for (int c = 0; c < 32; c++) begin
      for (int r = 0; r < 24; r++) begin
        if (c == 31 && r == 23) begin
          chk("sat_count_767", bus.dug_count, 767);
          chk("sat_all_dug_early", bus.all_dug, 0);
        end
        bus.Digger_X = 10'(c * 16 + 8);
        bus.Digger_Y = 10'(96 + r * 16 + 8);
        bus.frame_clk = 1'b1;
        tick();
        tick();
        bus.frame_clk = 1'b0;
        tick();
        tick();
      end
    end
    chk("sat_count", bus.dug_count, 768);
    chk("sat_all_dug", bus.all_dug, 1);
    chk("sat_map", bus.dug_state, {768{1'b1}});
    bus.frame_clk = 1'b1;
    tick();
    tick();
    chk("sat_redig_newly", bus.newly_dug, 0);
    chk("sat_hold", bus.dug_count, 768);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dig_map.md
# dig_map

Owns the playfield's dug-tile map. Marks the tile under the digger once per frame, keeps a running count of dug tiles, and serves a per-pixel "is dug" query to the colour mapper. Its `dug_state` output is the map that rock, enemy and collision logic read: a tile with its bit set is open tunnel. It also supports a multi-cycle level-clear sweep.

## Interface
- `INIT_COUNT`, default 0 (6 with `DIG_MAP_INIT_TUNNEL_EN`): value loaded into `dug_count` by reset and by clear.
- `Clk` in 1: system clock.
- `Reset` in 1: reset Reset, synchronous, active-high; clock Clk.
- `frame_clk` in 1: vertical-sync-rate frame strobe (asynchronous level).
- `Digger_X` in 10: digger centre X, in pixels.
- `Digger_Y` in 10: digger centre Y, in pixels.
- `Dig_en` in 1: digger is moving; a mark is allowed this frame.
- `Clear_map` in 1: start a level-clear sweep (level, single cycle).
- `DrawX` in 10: pixel query X.
- `DrawY` in 10: pixel query Y.
- `dug_state` out 24×[31:0]: `dug_state[col][row]`, 1 = dug.
- `is_dug` out 1: registered query result.
- `newly_dug` out 1: single-cycle pulse when a previously undug tile is marked.
- `dug_count` out 10: number of dug tiles.
- `all_dug` out 1: high when `dug_count` == 768.
- `Busy` out 1: clear sweep in progress.

## Operation
- **Tile mapping:**
  - col = X >> 4.
  - row = (Y − 96) >> 4.
  - A coordinate is valid only when X < 512 and 96 ≤ Y < 480. This gives 32 columns by 24 rows.
  - The subtraction is done in 10 bits, and the range check happens before the shift.
- **Frame edge:** two flops.
  - `frame_clk_delayed` <= `frame_clk`.
  - Edge pulse E <= `frame_clk` & ~`frame_clk_delayed`.
- **States:** IDLE, CLEAR.
- **IDLE:**
  - If `Clear_map` is high, go to CLEAR. Set col_idx = 0 and `dug_count` = `INIT_COUNT`. A simultaneous E is dropped.
  - Otherwise, on E with `Dig_en` high and the digger coordinate valid:
    - If the bit is 0: set it, increment `dug_count`, and pulse `newly_dug`.
    - If the bit is already 1: no change and no pulse.
- **CLEAR:**
  - Each cycle, write `dug_state[col_idx]` with the column's init pattern, then increment col_idx.
  - After col_idx = 31 is written, return to IDLE.
  - E and `Clear_map` are ignored in this state.
- **Query:** `is_dug` <= valid(`DrawX`, `DrawY`) ? `dug_state[col][row]` : 0.
- **Count:** saturates at 768. `all_dug` is combinational from `dug_count`.
- **Reset values:**
  - `dug_state` = init pattern.
  - `dug_count` = `INIT_COUNT`.
  - State IDLE; `Busy`, `newly_dug`, `is_dug` and `all_dug` all 0.
  - Both edge flops 0.
- **Reset during CLEAR:** abort the sweep immediately and apply the reset values.

## Timing
- `frame_clk` rising edge sampled at cycle t gives E high at t+1.
- A mark at E is visible at t+2 on `dug_state`, `dug_count` and `newly_dug`.
- `newly_dug` is high for exactly one cycle.
- `is_dug` has 1-cycle latency from `DrawX`/`DrawY`.
- **CLEAR sweep:**
  - `Clear_map` sampled at cycle c.
  - `Busy` is high from c+1 through c+32.
  - Column k is written at the end of cycle c+1+k.
  - IDLE resumes at c+33.
- The count load happens at c+1.
- A new `Clear_map` is accepted only in IDLE.

## Configuration
- `DIG_MAP_INIT_TUNNEL_EN` defined: the init pattern pre-digs column 15, rows 0–5 (starting tunnel), and `INIT_COUNT` = 6.
- Not defined: the init pattern is all zeros and `INIT_COUNT` = 0.
- The same pattern is used by both reset and CLEAR.

## Structure
- **`dig_map_pkg`:**
  - Constants: `MAP_COLS`=32, `MAP_ROWS`=24, `TILE_SHIFT`=4, `MAP_Y_ORIGIN`=96, `MAP_TILES`=768.
  - typedef `dug_col_t` (`logic[23:0]`) and typedef `dig_state_t` enum {IDLE, CLEAR}.
  - Function `init_col(col)` returning the pattern.
- **Sub-module `pix_to_tile`:** combinational. Takes X, Y and returns col, row and valid. Instantiated twice: once for the digger, once for the query.

## Test plan
- **Reset:** `Reset` for 2 cycles → `dug_count`=0, all `dug_state`=0, `Busy`=0. With the macro defined: `dug_state[15]`=24'h00003F and `dug_count`=6.
- **First dig:** `Digger_X`=40, `Digger_Y`=130, `Dig_en`=1, one `frame_clk` rise → `dug_state[2][2]`=1 two cycles after the sampled rise, `newly_dug` single pulse, `dug_count`=1.
- **Redig, disabled dig, out of range:**
  - Same tile on the next frame → count stays 1, no pulse.
  - `Dig_en`=0 → no change.
  - Y=90 or X=520 → no change.
- **Query:** `DrawX`=40, `DrawY`=130 → `is_dug`=1 the next cycle. `DrawY`=50 → `is_dug`=0.
- **Clear vs frame edge:** `Clear_map` in the same cycle as E → no mark. `Busy` high for exactly 32 cycles, all columns back to the init pattern, count = `INIT_COUNT`. A frame edge during `Busy` is ignored.
- **Reset mid-sweep, and saturation:**
  - `Reset` asserted 10 cycles into CLEAR → `Busy`=0 next cycle, reset values applied.
  - Dig all 768 tiles → `all_dug`=1, `dug_count` holds at 768.
